// File: rtl/gmt_cmd_issuer.sv
// Geometry-command issuer: buffers CPU geometry commands in a small FIFO and
// hands them to the matrix unit one at a time with a go/busy protocol.
//
// Handshakes:
//   CPU side  : a command is taken on a clk edge where cmd_vld & cmd_rdy.
//               cmd_rdy is a registered view of FIFO occupancy (count < DEPTH),
//               so a pop in the same cycle never makes room early.
//   Matrix side: go is a single-cycle strobe; the issued fields stay stable
//               from the load edge until the next pop. The unit raises busy
//               within one cycle of go; the issuer waits for busy to fall,
//               then leaves one gap cycle before looking at the FIFO again.
//   Creates (op 0) popped while obj_mem_full is high are discarded and flagged
//   on the sticky drop_err (err_clr wins over a same-cycle set).
module gmt_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int VW    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_vld,
  output logic                         cmd_rdy,
  input  logic [3:0]                   cmd_op,
  input  logic [3:0]                   cmd_code,
  input  logic [4:0]                   cmd_num,
  input  logic [1:0]                   cmd_type,
  input  logic [7:0]                   cmd_color,
  input  logic [8*VW-1:0]              cmd_v,
  output logic                         go,
  output logic [3:0]                   gmt_op,
  output logic [3:0]                   gmt_code,
  output logic [4:0]                   obj_num_in,
  output logic [1:0]                   obj_type,
  output logic [7:0]                   obj_color,
  output logic [VW-1:0]                v0,
  output logic [VW-1:0]                v1,
  output logic [VW-1:0]                v2,
  output logic [VW-1:0]                v3,
  output logic [VW-1:0]                v4,
  output logic [VW-1:0]                v5,
  output logic [VW-1:0]                v6,
  output logic [VW-1:0]                v7,
  input  logic                         busy,
  input  logic                         obj_mem_full,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         idle,
  output logic                         drop_err,
  input  logic                         err_clr
);

  localparam int CW       = $clog2(DEPTH + 1);
  localparam int PW       = $clog2(DEPTH);
  localparam int COLOR_LO = 8 * VW;
  localparam int TYPE_LO  = COLOR_LO + 8;
  localparam int NUM_LO   = TYPE_LO + 2;
  localparam int CODE_LO  = NUM_LO + 5;
  localparam int OP_LO    = CODE_LO + 4;
  localparam int EW       = OP_LO + 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_HOLD  = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [EW-1:0]   head;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   out_q;
  logic            push;
  logic            pop;
  logic            drop;

  assign push     = cmd_vld & cmd_rdy;
  assign head     = mem[rd_ptr];
  assign wr_entry = {cmd_op, cmd_code, cmd_num, cmd_type, cmd_color, cmd_v};

  // Command storage; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Occupancy after this edge: push and pop together leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cmd_rdy <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_nxt;
      cmd_rdy <= (count_nxt < CW'(DEPTH));
    end
  end

  // Issue sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus pop/drop decisions; only IDLE ever pops, at most once.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          if ((head[OP_LO +: 4] == 4'd0) && obj_mem_full) drop = 1'b1;
          else                                            state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_HOLD;
      // busy is deliberately ignored here so the unit has a cycle to raise it.
      S_HOLD:  state_nxt = S_WAIT;
      S_WAIT:  if (!busy) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issued fields load on every pop and are held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_q <= '0;
    else if (pop) out_q <= head;
  end

  // Sticky drop flag; a clear in the same cycle as a drop wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       drop_err <= 1'b0;
    else if (err_clr) drop_err <= 1'b0;
    else if (drop)    drop_err <= 1'b1;
  end

  assign go         = (state == S_ISSUE);
  assign idle       = (count == '0) && (state == S_IDLE);
  assign pending    = count;
  assign gmt_op     = out_q[OP_LO +: 4];
  assign gmt_code   = out_q[CODE_LO +: 4];
  assign obj_num_in = out_q[NUM_LO +: 5];
  assign obj_type   = out_q[TYPE_LO +: 2];
  assign obj_color  = out_q[COLOR_LO +: 8];
  assign v0         = out_q[0*VW +: VW];
  assign v1         = out_q[1*VW +: VW];
  assign v2         = out_q[2*VW +: VW];
  assign v3         = out_q[3*VW +: VW];
  assign v4         = out_q[4*VW +: VW];
  assign v5         = out_q[5*VW +: VW];
  assign v6         = out_q[6*VW +: VW];
  assign v7         = out_q[7*VW +: VW];

endmodule

// File: tb/tb_gmt_cmd_issuer.sv
// Bench for gmt_cmd_issuer: directed scenarios, a timestamp-based reference
// model compared on every falling edge, and literal spot checks.
module tb_gmt_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int VW    = 16;

  typedef struct packed {
    logic [3:0]      op;
    logic [3:0]      code;
    logic [4:0]      num;
    logic [1:0]      typ;
    logic [7:0]      color;
    logic [8*VW-1:0] v;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            cmd_vld = 1'b0;
  logic            cmd_rdy;
  cmd_t            drv = '0;
  logic            go;
  logic [3:0]      gmt_op, gmt_code;
  logic [4:0]      obj_num_in;
  logic [1:0]      obj_type;
  logic [7:0]      obj_color;
  logic [VW-1:0]   v0, v1, v2, v3, v4, v5, v6, v7;
  logic            busy = 1'b0;
  logic            obj_mem_full = 1'b0;
  logic [2:0]      pending;
  logic            idle;
  logic            drop_err;
  logic            err_clr = 1'b0;

  gmt_cmd_issuer #(.DEPTH(DEPTH), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_op(drv.op), .cmd_code(drv.code), .cmd_num(drv.num),
    .cmd_type(drv.typ), .cmd_color(drv.color), .cmd_v(drv.v),
    .go(go), .gmt_op(gmt_op), .gmt_code(gmt_code), .obj_num_in(obj_num_in),
    .obj_type(obj_type), .obj_color(obj_color),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
    .busy(busy), .obj_mem_full(obj_mem_full),
    .pending(pending), .idle(idle), .drop_err(drop_err), .err_clr(err_clr)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int go_cnt = 0;
  logic [4:0] go_num_log[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- matrix-unit responder ----------------
  // Raises busy the cycle after go for resp_len cycles; force_busy pins it high.
  int resp_len   = 3;
  int resp_cnt   = 0;
  bit resp_arm   = 0;
  bit force_busy = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      resp_cnt = 0;
      resp_arm = 0;
    end else begin
      if (resp_cnt > 0) resp_cnt--;
      if (resp_arm) begin
        resp_cnt = resp_len;
        resp_arm = 0;
      end
      if (go) resp_arm = 1;
    end
    busy = force_busy || (resp_cnt > 0);
  end

  // ---------------- reference model ----------------
  // Commands wait in a queue. A popped command is "in flight" from its pop
  // edge; busy is first looked at three edges later, and the issuer may pop
  // again two edges after the edge where busy was seen low.
  cmd_t mq[$];
  cmd_t m_out      = '0;
  bit   m_fly      = 0;
  bit   m_go       = 0;
  bit   m_drop_err = 0;
  int   m_cyc      = 0;
  int   m_pop_cyc  = 0;
  int   m_fall_cyc = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_out      = '0;
      m_fly      = 0;
      m_go       = 0;
      m_drop_err = 0;
      m_cyc      = 0;
      m_fall_cyc = -1;
    end else begin
      bit   will_push;
      bit   can_pop;
      cmd_t h;
      m_cyc++;
      will_push = cmd_vld && (mq.size() < DEPTH);
      can_pop   = !m_fly && (mq.size() > 0);
      m_go      = 0;
      if (m_fly) begin
        if (m_fall_cyc < 0 && m_cyc >= m_pop_cyc + 3 && !busy) m_fall_cyc = m_cyc;
        else if (m_fall_cyc >= 0 && m_cyc == m_fall_cyc + 1)   m_fly = 0;
      end
      if (can_pop) begin
        h     = mq.pop_front();
        m_out = h;
        if (h.op == 4'd0 && obj_mem_full) begin
          m_drop_err = 1;
        end else begin
          m_fly      = 1;
          m_go       = 1;
          m_pop_cyc  = m_cyc;
          m_fall_cyc = -1;
        end
      end
      if (err_clr) m_drop_err = 0;
      if (will_push) mq.push_back(drv);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("go", go, m_go);
    chk("cmd_rdy", cmd_rdy, mq.size() < DEPTH);
    chk("pending", pending, mq.size());
    chk("idle", idle, (mq.size() == 0) && !m_fly);
    chk("drop_err", drop_err, m_drop_err);
    chk("gmt_op", gmt_op, m_out.op);
    chk("gmt_code", gmt_code, m_out.code);
    chk("obj_num_in", obj_num_in, m_out.num);
    chk("obj_type", obj_type, m_out.typ);
    chk("obj_color", obj_color, m_out.color);
    chk("v_words", {v7, v6, v5, v4, v3, v2, v1, v0}, m_out.v);
    if (go) begin
      go_cnt++;
      go_num_log.push_back(obj_num_in);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [3:0] code, input logic [4:0] num,
                         input logic [1:0] typ, input logic [7:0] color, input logic [127:0] v);
    drv.op    = op;
    drv.code  = code;
    drv.num   = num;
    drv.typ   = typ;
    drv.color = color;
    drv.v     = v;
    cmd_vld   = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (idle && !busy) break;
    end
    chk(name, idle, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    int base_log;
    bit accepted;

    // Reset state
    repeat (3) step();
    chk("rst_go", go, 1'b0);
    chk("rst_rdy", cmd_rdy, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_pending", pending, 3'd0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_no_go", go_cnt, 0);

    // Single create with a 3-cycle busy
    resp_len = 3;
    base = go_cnt;
    set_cmd(4'd0, 4'd0, 5'd5, 2'd3, 8'h1C, 128'h0);
    step();
    cmd_vld = 1'b0;
    chk("t2_pending", pending, 3'd1);
    chk("t2_no_go_yet", go, 1'b0);
    step();
    chk("t2_go", go, 1'b1);
    chk("t2_op", gmt_op, 4'd0);
    chk("t2_type", obj_type, 2'd3);
    chk("t2_color", obj_color, 8'h1C);
    repeat (4) step();
    chk("t2_color_held", obj_color, 8'h1C);
    step();
    chk("t2_gap_not_idle", idle, 1'b0);
    step();
    chk("t2_idle", idle, 1'b1);
    chk("t2_one_go", go_cnt - base, 1);

    // Burst of 6 with busy held high
    force_busy = 1;
    step();
    base     = go_cnt;
    base_log = go_num_log.size();
    for (int i = 0; i < 6; i++) begin
      set_cmd(4'd4, 4'(i), 5'(i + 1), 2'd0, 8'(8'h40 + i), {8{16'(i * 10)}});
      step();
    end
    chk("t3_rdy_low", cmd_rdy, 1'b0);
    chk("t3_pending4", pending, 3'd4);
    repeat (4) step();
    chk("t3_rdy_still_low", cmd_rdy, 1'b0);
    force_busy = 0;
    accepted = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cmd_rdy) begin
        accepted = 1;
        step();
        break;
      end
    end
    cmd_vld = 1'b0;
    chk("t3_sixth_accepted", accepted, 1'b1);
    wait_idle("t3_drain", 300);
    chk("t3_go_count", go_cnt - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base_log + i < go_num_log.size())
        chk("t3_go_order", go_num_log[base_log + i], 5'(i + 1));
      else
        chk("t3_go_missing", 1'b0, 1'b1);
    end

    // Create dropped while object memory is full, translate still issued
    obj_mem_full = 1'b1;
    base = go_cnt;
    set_cmd(4'd0, 4'd0, 5'd2, 2'd1, 8'h33, 128'h0);
    step();
    set_cmd(4'd4, 4'd2, 5'd1, 2'd0, 8'h00, {112'h0, 16'd300});
    step();
    cmd_vld = 1'b0;
    chk("t4_drop_err_set", drop_err, 1'b1);
    step();
    chk("t4_go", go, 1'b1);
    chk("t4_op", gmt_op, 4'd4);
    chk("t4_v0", v0, 16'd300);
    wait_idle("t4_drain", 100);
    chk("t4_one_go", go_cnt - base, 1);
    // clear that coincides with another drop: the clear must win
    err_clr = 1'b1;
    set_cmd(4'd0, 4'd0, 5'd3, 2'd2, 8'h44, 128'h0);
    step();
    cmd_vld = 1'b0;
    step();
    chk("t4_clr_priority", drop_err, 1'b0);
    err_clr = 1'b0;
    step();
    chk("t4_cleared", drop_err, 1'b0);
    chk("t4_no_go_for_create", go_cnt - base, 1);
    obj_mem_full = 1'b0;

    // Signed operand held across a 10-cycle busy
    resp_len = 10;
    set_cmd(4'd4, 4'd3, 5'd0, 2'd0, 8'h00,
            {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'hFF6A});
    step();
    cmd_vld = 1'b0;
    step();
    chk("t5_go", go, 1'b1);
    chk("t5_v0", v0, 16'hFF6A);
    chk("t5_v3", v3, 16'h3333);
    repeat (8) step();
    chk("t5_v0_held", v0, 16'hFF6A);
    chk("t5_v7_held", v7, 16'h7777);
    wait_idle("t5_drain", 100);
    resp_len = 3;

    // Reset while waiting on busy with two commands queued
    force_busy = 1;
    base = go_cnt;
    for (int i = 0; i < 3; i++) begin
      set_cmd(4'd5, 4'd1, 5'(20 + i), 2'd0, 8'h10, 128'h0);
      step();
    end
    cmd_vld = 1'b0;
    chk("t6_pending2", pending, 3'd2);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", pending, 3'd0);
    chk("t6_rst_idle", idle, 1'b1);
    chk("t6_rst_rdy", cmd_rdy, 1'b1);
    chk("t6_rst_go", go, 1'b0);
    chk("t6_rst_op", gmt_op, 4'd0);
    chk("t6_rst_num", obj_num_in, 5'd0);
    force_busy = 0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("t6_no_go_after_reset", go_cnt - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
